// File: rtl/commit_unit_pkg.sv
// Shared types for the retirement stage and the instruction buffer it drains.
package commit_unit_pkg;

   localparam int unsigned BUF_SIZE_LOG = 4;
   localparam int unsigned BUF_SIZE     = 1 << BUF_SIZE_LOG;
   localparam int unsigned SPEC_W       = 6;
   localparam int unsigned REG_W        = 5;
   localparam int unsigned DATA_W       = 32;

   typedef logic bool;

   typedef enum logic [1:0] {S_NOT_USED, S_WAITING, S_EXECUTING, S_EXECUTED} state_t;
   typedef enum logic [1:0] {ALU, BRANCH, LOAD, STORE} unit_t;
   typedef enum logic [2:0] {BYTE = 3'd0, HALF, WORD, BYTE_U, HALF_U} ldst_mode_t;

   typedef logic [SPEC_W-1:0]       spectag_t;
   typedef logic [BUF_SIZE_LOG-1:0] tag_t;
   typedef logic [BUF_SIZE_LOG-1:0] index_t;

   typedef struct packed {
      state_t            e_state;
      spectag_t          speculative_tag;
      unit_t             Unit;
      tag_t              tag;
      logic [REG_W-1:0]  Dest;
      logic [DATA_W-1:0] result;
      logic [DATA_W-1:0] A;
      logic [DATA_W-1:0] Vk;
      ldst_mode_t        rwmm;
   } entry_t;

   typedef enum logic {C_IDLE, C_STORE_WAIT} commit_state_t;

endpackage

// File: rtl/commit_unit_slot_check.sv
// Per-entry qualification: retirable, store, and whether retiring it writes the register file.
module commit_slot_check
   import commit_unit_pkg::*;
(
   input  state_t           e_state,
   input  spectag_t         spec_tag,
   input  unit_t            fu_unit,
   input  logic [REG_W-1:0] dest,
   output logic             retirable_c,
   output logic             is_store_c,
   output logic             writes_rf_c
);

   // Executed and no longer under any speculative branch; x0 is never written
   always_comb begin
      retirable_c = (e_state == S_EXECUTED) && (spec_tag == '0);
      is_store_c  = (fu_unit == STORE);
      writes_rf_c = (dest != '0) && (fu_unit != STORE);
   end

endmodule

// File: rtl/flopr_n.sv
// Plain D flop bank with asynchronous active-low clear.
module flopr_n #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   // Clear on reset, otherwise capture d every rising edge
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) q <= '0;
      else        q <= d;
   end

endmodule

// File: rtl/commit_unit.sv
// In-order retirement of the two oldest buffer entries, with stores drained through a memory handshake.
module commit_unit
   import commit_unit_pkg::*;
#(
   parameter int unsigned BUF_SIZE_LOG = commit_unit_pkg::BUF_SIZE_LOG,
   parameter int unsigned CNT_W        = 32
) (
   input  logic                         clk,
   input  logic                         reset,
   input  entry_t [1:0]                 head,
   input  logic                         mem_ack,
   output logic [1:0]                   is_really_commited,
   output logic [1:0]                   is_commited_store,
   output logic [1:0]                   rf_we,
   output logic [1:0][REG_W-1:0]        rf_waddr,
   output logic [1:0][DATA_W-1:0]       rf_wdata,
   output logic [1:0][BUF_SIZE_LOG-1:0] commit_tag,
   output logic                         mem_req,
   output logic [DATA_W-1:0]            mem_addr,
   output logic [DATA_W-1:0]            mem_wdata,
   output logic [2:0]                   mem_mode,
   output logic [CNT_W-1:0]             retired_count
);

   commit_state_t              state_q, state_d;
   logic [0:0]                 state_raw;
   logic [1:0]                 retirable, is_store, writes_rf;
   logic                       mem_req_d;
   logic [DATA_W-1:0]          mem_addr_d, mem_wdata_d;
   logic [2:0]                 mem_mode_d;
   logic [CNT_W-1:0]           retired_count_d;
   logic                       unused_head1;

   // Store payload of slot 1 is never consumed: stores only retire from the head
   assign unused_head1 = ^{head[1].A, head[1].Vk, head[1].rwmm};

   for (genvar k = 0; k < 2; k++) begin : g_slot
      commit_slot_check u_chk (
         .e_state     (head[k].e_state),
         .spec_tag    (head[k].speculative_tag),
         .fu_unit     (head[k].Unit),
         .dest        (head[k].Dest),
         .retirable_c (retirable[k]),
         .is_store_c  (is_store[k]),
         .writes_rf_c (writes_rf[k])
      );
   end

   // State register
   flopr_n #(.WIDTH(1)) u_state_ff (.clk(clk), .reset(reset), .d(state_d), .q(state_raw));
   assign state_q = commit_state_t'(state_raw);

   // Next state: enter the wait on a retirable store at the head, leave on ack
   always_comb begin
      state_d = state_q;
      case (state_q)
         C_IDLE:       if (retirable[0] && is_store[0]) state_d = C_STORE_WAIT;
         C_STORE_WAIT: if (mem_ack)                     state_d = C_IDLE;
         default:      state_d = C_IDLE;
      endcase
   end

   // Outputs: retirement decisions, RF write port and next values of registered outputs
   always_comb begin
      is_really_commited = 2'b00;
      is_commited_store  = 2'b00;
      mem_req_d          = mem_req;
      mem_addr_d         = mem_addr;
      mem_wdata_d        = mem_wdata;
      mem_mode_d         = mem_mode;
      case (state_q)
         C_IDLE: begin
            mem_req_d = 1'b0;
            if (retirable[0] && !is_store[0]) begin
               is_really_commited[0] = 1'b1;
               is_really_commited[1] = retirable[1] && !is_store[1];
            end else if (retirable[0]) begin
               mem_req_d   = 1'b1;
               mem_addr_d  = head[0].A;
               mem_wdata_d = head[0].Vk;
               mem_mode_d  = head[0].rwmm;
            end
         end
         C_STORE_WAIT: begin
            if (mem_ack) begin
               is_really_commited[0] = 1'b1;
               is_commited_store[0]  = 1'b1;
               mem_req_d             = 1'b0;
            end
         end
         default: mem_req_d = 1'b0;
      endcase
      retired_count_d = retired_count + CNT_W'(is_really_commited[0])
                                      + CNT_W'(is_really_commited[1]);
      for (int k = 0; k < 2; k++) begin
         rf_we[k]      = is_really_commited[k] && writes_rf[k];
         rf_waddr[k]   = head[k].Dest;
         rf_wdata[k]   = head[k].result;
         commit_tag[k] = BUF_SIZE_LOG'(head[k].tag);
      end
   end

   // Registered store request, payload and retirement counter
   flopr_n #(.WIDTH(1))      u_req_ff   (.clk(clk), .reset(reset), .d(mem_req_d),       .q(mem_req));
   flopr_n #(.WIDTH(DATA_W)) u_addr_ff  (.clk(clk), .reset(reset), .d(mem_addr_d),      .q(mem_addr));
   flopr_n #(.WIDTH(DATA_W)) u_wdata_ff (.clk(clk), .reset(reset), .d(mem_wdata_d),     .q(mem_wdata));
   flopr_n #(.WIDTH(3))      u_mode_ff  (.clk(clk), .reset(reset), .d(mem_mode_d),      .q(mem_mode));
   flopr_n #(.WIDTH(CNT_W))  u_cnt_ff   (.clk(clk), .reset(reset), .d(retired_count_d), .q(retired_count));

endmodule
